// File: rtl/elevator_request_scheduler.sv
// ============================================================================
// elevator_request_scheduler: LOOK-policy floor-call scheduler with door dwell
// Rev 1.0
// ============================================================================
`default_nettype none

module elevator_request_scheduler #(
  parameter int          NUM_FLOORS = 10,
  parameter logic [31:0] DOOR_TICKS = 32'd20000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [3:0]            current_floor,
  input  logic                  car_idle,
  output logic [3:0]            target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_TRAVEL   = 2'd2,
    S_DOOR     = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
  logic [NUM_FLOORS-1:0] w_cf_mask, w_set, w_clr;
  logic [3:0]            r_target, w_target_nxt;
  logic                  r_door_open, w_door_nxt;
  logic                  r_dir_up, w_dir_nxt;
  logic                  r_busy;
  logic [31:0]           r_count, w_count_nxt;
  logic                  w_above_found, w_below_found;
  logic [3:0]            w_above_idx, w_below_idx;
  logic                  w_at_call, w_reopen;

  // One-hot of the car position; all zero when the car reports an unserved floor
  always_comb begin
    w_cf_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_cf_mask[i] = (current_floor == 4'(i));
    end
  end

  // Nearest pending call above (lowest index) and below (highest index)
  always_comb begin
    w_above_found = 1'b0;
    w_above_idx   = 4'd0;
    w_below_found = 1'b0;
    w_below_idx   = 4'd0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (4'(i) > current_floor)) begin
        w_above_found = 1'b1;
        w_above_idx   = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i] && (4'(i) < current_floor)) begin
        w_below_found = 1'b1;
        w_below_idx   = 4'(i);
      end
    end
  end

  assign w_at_call = |(r_pending & w_cf_mask);
  assign w_reopen  = (r_state == S_DOOR) && (|(call_req & w_cf_mask));
  // A press at the floor whose doors are open reopens them instead of latching
  assign w_set     = call_req & ~({NUM_FLOORS{r_state == S_DOOR}} & w_cf_mask);
  assign w_pending_nxt = (r_pending | w_set) & ~w_clr;

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_door_nxt   = r_door_open;
    w_dir_nxt    = r_dir_up;
    w_count_nxt  = r_count;
    w_clr        = '0;
    case (r_state)
      S_IDLE: begin
        w_target_nxt = current_floor;
        if (|r_pending) w_state_nxt = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (!(|r_pending)) begin
          w_state_nxt = S_IDLE;
        end else if (w_at_call) begin
          w_state_nxt  = S_DOOR;
          w_target_nxt = current_floor;
          w_door_nxt   = 1'b1;
          w_count_nxt  = 32'd0;
          w_clr        = w_cf_mask;
        end else if (r_dir_up && w_above_found) begin
          w_state_nxt  = S_TRAVEL;
          w_target_nxt = w_above_idx;
        end else if (!r_dir_up && w_below_found) begin
          w_state_nxt  = S_TRAVEL;
          w_target_nxt = w_below_idx;
        end else if (r_dir_up) begin
          w_state_nxt  = S_TRAVEL;
          w_dir_nxt    = 1'b0;
          w_target_nxt = w_below_idx;
        end else begin
          w_state_nxt  = S_TRAVEL;
          w_dir_nxt    = 1'b1;
          w_target_nxt = w_above_idx;
        end
      end
      S_TRAVEL: begin
        if ((current_floor == r_target) && car_idle) begin
          w_state_nxt = S_DOOR;
          w_door_nxt  = 1'b1;
          w_count_nxt = 32'd0;
          w_clr       = w_cf_mask;
        end else if ((r_target > current_floor) && w_above_found &&
                     (w_above_idx < r_target)) begin
          w_target_nxt = w_above_idx;
        end else if ((r_target < current_floor) && w_below_found &&
                     (w_below_idx > r_target)) begin
          w_target_nxt = w_below_idx;
        end
      end
      S_DOOR: begin
        if (w_reopen) begin
          w_count_nxt = 32'd0;
        end else if (r_count >= (DOOR_TICKS - 32'd1)) begin
          w_door_nxt  = 1'b0;
          w_state_nxt = (|r_pending) ? S_DISPATCH : S_IDLE;
        end else begin
          w_count_nxt = r_count + 32'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_target    <= 4'd0;
      r_door_open <= 1'b0;
      r_dir_up    <= 1'b1;
      r_count     <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_target    <= w_target_nxt;
      r_door_open <= w_door_nxt;
      r_dir_up    <= w_dir_nxt;
      r_count     <= w_count_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign target_floor = r_target;
  assign pending      = r_pending;
  assign door_open    = r_door_open;
  assign dir_up       = r_dir_up;
  assign busy         = r_busy;

endmodule

`default_nettype wire
